// File: rtl/l1d_slot_pkg.sv
// l1d_slot_pkg: shared definitions for L1D slot tracking.
//   id_width()  - ID width for a given slot count, same clog2 rule as the priority encoder
//   cnt_width() - width that can hold a busy count of 0..sel_width
//   err_code_e  - protocol-error codes used by scoreboards
//   err_pulse_t - bundle of the tracker's one-cycle error pulses
package l1d_slot_pkg;

    function automatic int unsigned id_width(input int unsigned sel_width);
        return (sel_width > 1) ? $clog2(sel_width) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned sel_width);
        return $clog2(sel_width + 1);
    endfunction

    typedef enum logic [1:0] {
        ERR_DUP_SET  = 2'd0,
        ERR_FREE_CLR = 2'd1,
        ERR_RANGE    = 2'd2
    } err_code_e;

    typedef struct packed {
        logic dup_set;
        logic free_clr;
        logic out_of_range;
    } err_pulse_t;

endpackage

// File: rtl/id_decoder.sv
// id_decoder: combinational binary-ID to one-hot decoder.
//   id       - binary slot ID
//   onehot   - decoded slot, all-zero when id is out of range
//   in_range - id addresses an existing slot
module id_decoder
    import l1d_slot_pkg::*;
#(
    parameter  int unsigned SEL_WIDTH = 8,
    localparam int unsigned ID_WIDTH  = id_width(SEL_WIDTH)
) (
    input  logic [ID_WIDTH-1:0]  id,
    output logic [SEL_WIDTH-1:0] onehot,
    output logic                 in_range
);

    if (SEL_WIDTH == 1) begin : g_single
        // A single slot is always slot 0; the ID carries no information.
        logic unused_id;
        assign unused_id = ^id;
        assign onehot    = SEL_WIDTH'(1);
        assign in_range  = 1'b1;
    end else begin : g_multi
        // Compare against each legal ID; IDs past the last slot match nothing.
        always_comb begin
            onehot = '0;
            for (int unsigned i = 0; i < SEL_WIDTH; i++) begin
                onehot[i] = (id == ID_WIDTH'(i));
            end
        end
        assign in_range = |onehot;
    end

endmodule

// File: rtl/id_onehot_tracker.sv
// id_onehot_tracker: registered slot-occupancy vector with count, flags and
// protocol-error pulses. All outputs are registered (one-cycle latency).
//   clk, rst_n             - clock, synchronous active-low reset
//   set_vld_i / set_id_i   - allocate a slot
//   clr_vld_i / clr_id_i   - release a slot
//   flush_i                - free every slot, drop concurrent requests
//   sel_o                  - occupancy vector, bit i = slot i busy
//   set_oh_o               - one-hot of the set accepted last cycle
//   cnt_o, full_o, empty_o - busy count and its flags
//   err_dup_set_o          - set of a busy slot
//   err_free_clr_o         - clear of a free slot
//   err_range_o            - set or clear ID beyond the last slot
module id_onehot_tracker
    import l1d_slot_pkg::*;
#(
    parameter  int unsigned SEL_WIDTH = 8,
    localparam int unsigned ID_WIDTH  = id_width(SEL_WIDTH),
    localparam int unsigned CNT_WIDTH = cnt_width(SEL_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_vld_i,
    input  logic [ID_WIDTH-1:0]  set_id_i,
    input  logic                 clr_vld_i,
    input  logic [ID_WIDTH-1:0]  clr_id_i,
    input  logic                 flush_i,
    output logic [SEL_WIDTH-1:0] sel_o,
    output logic [SEL_WIDTH-1:0] set_oh_o,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 err_dup_set_o,
    output logic                 err_free_clr_o,
    output logic                 err_range_o
);

    logic [SEL_WIDTH-1:0] set_dec;
    logic [SEL_WIDTH-1:0] clr_dec;
    logic                 set_in_range;
    logic                 clr_in_range;

    id_decoder #(.SEL_WIDTH(SEL_WIDTH)) u_set_dec (
        .id       (set_id_i),
        .onehot   (set_dec),
        .in_range (set_in_range)
    );

    id_decoder #(.SEL_WIDTH(SEL_WIDTH)) u_clr_dec (
        .id       (clr_id_i),
        .onehot   (clr_dec),
        .in_range (clr_in_range)
    );

    logic [SEL_WIDTH-1:0] sel_q;
    logic [SEL_WIDTH-1:0] set_oh_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 full_q;
    logic                 empty_q;
    err_pulse_t           err_q;

    logic                 set_req;
    logic                 clr_req;
    logic                 set_busy;
    logic                 clr_busy;
    logic                 same_id;
    logic                 set_applied;
    logic                 clr_applied;
    logic [SEL_WIDTH-1:0] sel_d;
    logic [SEL_WIDTH-1:0] set_oh_d;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 full_d;
    logic                 empty_d;
    err_pulse_t           err_d;

    // Request qualification against the registered occupancy vector.
    always_comb begin
        set_req  = set_vld_i & set_in_range;
        clr_req  = clr_vld_i & clr_in_range;
        set_busy = |(set_dec & sel_q);
        clr_busy = |(clr_dec & sel_q);
        same_id  = set_req & clr_req & (set_dec == clr_dec);

        clr_applied = clr_req & clr_busy;
        // Same-ID set on a busy slot is release-then-reallocate, so it is accepted.
        set_applied = set_req & (~set_busy | same_id);
    end

    // Next-state computation; flush wins over every request and error.
    always_comb begin
        sel_d    = sel_q;
        set_oh_d = '0;
        cnt_d    = cnt_q;
        err_d    = '0;

        if (!flush_i) begin
            sel_d    = (sel_q & ~({SEL_WIDTH{clr_applied}} & clr_dec))
                     | ({SEL_WIDTH{set_applied}} & set_dec);
            set_oh_d = {SEL_WIDTH{set_applied}} & set_dec;
            // Incremental count; same-ID reallocation nets to zero.
            cnt_d    = cnt_q + CNT_WIDTH'(set_applied) - CNT_WIDTH'(clr_applied);

            err_d.dup_set      = set_req & set_busy & ~same_id;
            err_d.free_clr     = clr_req & ~clr_busy;
            err_d.out_of_range = (set_vld_i & ~set_in_range) | (clr_vld_i & ~clr_in_range);
        end else begin
            sel_d = '0;
            cnt_d = '0;
        end

        full_d  = (cnt_d == CNT_WIDTH'(SEL_WIDTH));
        empty_d = (cnt_d == '0);
    end

    // State, count and pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q    <= '0;
            set_oh_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            err_q    <= '0;
        end else begin
            sel_q    <= sel_d;
            set_oh_q <= set_oh_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            err_q    <= err_d;
        end
    end

    assign sel_o          = sel_q;
    assign set_oh_o       = set_oh_q;
    assign cnt_o          = cnt_q;
    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign err_dup_set_o  = err_q.dup_set;
    assign err_free_clr_o = err_q.free_clr;
    assign err_range_o    = err_q.out_of_range;

    // The incremental count must always equal the number of busy slots.
    a_cnt_tracks_sel: assert property (@(posedge clk) disable iff (!rst_n)
        32'(cnt_q) == 32'($countones(sel_q)));

    // An accepted set names exactly one slot, and that slot is now busy.
    a_set_oh_valid: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(set_oh_q) && ((set_oh_q & ~sel_q) == '0));

endmodule
